// File: rtl/coletor_sensores.sv
// coletor_sensores
//
// Collects one 4-bit reading from each of the four plant sensors over a
// shared bus. It publishes them together as one coherent set for the
// averaging stage.
//
// Ports:
//   clock              rising-edge clock
//   reset              synchronous, active-high
//   inicio             start request, sampled only while idle
//   dado_in[3:0]       shared sensor bus data
//   dado_valido        sensor strobe, dado_in valid in the same cycle
//   sel_sensor[1:0]    addressed sensor (0 temp, 1 pH, 2 lum, 3 umid)
//   pede               request to the addressed sensor (waiting state)
//   temperatura, pH, luminosidade, umidade [3:0]
//                      last complete set
//   enable             one-cycle pulse, a new set is visible
//   ocupado            acquisition in progress or publishing
//   erro               sticky timeout flag
//   contagem_leituras  completed sets, modulo 256
module coletor_sensores #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       inicio,
  input  logic [3:0] dado_in,
  input  logic       dado_valido,
  output logic [1:0] sel_sensor,
  output logic       pede,
  output logic [3:0] temperatura,
  output logic [3:0] pH,
  output logic [3:0] luminosidade,
  output logic [3:0] umidade,
  output logic       enable,
  output logic       ocupado,
  output logic       erro,
  output logic [7:0] contagem_leituras
);

  typedef enum logic [1:0] {
    OCIOSO = 2'd0,
    ESPERA = 2'd1,
    PRONTO = 2'd2
  } state_t;

  localparam logic [7:0] TIMEOUT_W = TIMEOUT[7:0];

  state_t     state_q, state_d;
  logic [1:0] sel_q, sel_d;
  logic [7:0] cnt_q, cnt_d;
  logic       erro_q, erro_d;
  logic [7:0] sets_q, sets_d;
  // Shadow copies of sensors 0..2. Sensor 3 goes straight to the visible
  // output because its capture edge is also the publish edge.
  logic [3:0] sh0_q, sh0_d, sh1_q, sh1_d, sh2_q, sh2_d;
  logic [3:0] temp_q, temp_d, ph_q, ph_d, lum_q, lum_d, umid_q, umid_d;

  logic       timeout_hit;

  // A strobe on the same cycle wins over the timeout.
  assign timeout_hit = !dado_valido && ((cnt_q + 8'd1) == TIMEOUT_W);

  // State register and datapath registers.
  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= OCIOSO;
      sel_q   <= 2'd0;
      cnt_q   <= 8'd0;
      erro_q  <= 1'b0;
      sets_q  <= 8'd0;
      // NOTE: the shadow registers are explicitly cleared too, so a reset in
      // mid-acquisition leaves no stale partial set behind.
      sh0_q   <= 4'd0;
      sh1_q   <= 4'd0;
      sh2_q   <= 4'd0;
      temp_q  <= 4'd0;
      ph_q    <= 4'd0;
      lum_q   <= 4'd0;
      umid_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      erro_q  <= erro_d;
      sets_q  <= sets_d;
      sh0_q   <= sh0_d;
      sh1_q   <= sh1_d;
      sh2_q   <= sh2_d;
      temp_q  <= temp_d;
      ph_q    <= ph_d;
      lum_q   <= lum_d;
      umid_q  <= umid_d;
    end
  end

  // Next-state logic.
  // NOTE: every combinational output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      OCIOSO: if (inicio) state_d = ESPERA;
      ESPERA: begin
        if (dado_valido) begin
          if (sel_q == 2'd3) state_d = PRONTO;
        end else if (timeout_hit) begin
          state_d = OCIOSO;
        end
      end
      PRONTO:  state_d = OCIOSO;
      default: state_d = OCIOSO;
    endcase
  end

  // Datapath next values. The last capture also loads all four visible
  // readings at once, so the outputs never show a mixed set.
  always_comb begin
    sel_d  = sel_q;
    cnt_d  = cnt_q;
    erro_d = erro_q;
    sets_d = sets_q;
    sh0_d  = sh0_q;
    sh1_d  = sh1_q;
    sh2_d  = sh2_q;
    temp_d = temp_q;
    ph_d   = ph_q;
    lum_d  = lum_q;
    umid_d = umid_q;

    if (state_q == OCIOSO && inicio) begin
      sel_d  = 2'd0;
      cnt_d  = 8'd0;
      erro_d = 1'b0;
    end else if (state_q == ESPERA) begin
      if (dado_valido) begin
        cnt_d = 8'd0;
        unique case (sel_q)
          2'd0: sh0_d = dado_in;
          2'd1: sh1_d = dado_in;
          2'd2: sh2_d = dado_in;
          2'd3: begin
            temp_d = sh0_q;
            ph_d   = sh1_q;
            lum_d  = sh2_q;
            umid_d = dado_in;
            sets_d = sets_q + 8'd1;
          end
          default: ;
        endcase
        if (sel_q != 2'd3) sel_d = sel_q + 2'd1;
      end else begin
        cnt_d = cnt_q + 8'd1;
        if (timeout_hit) erro_d = 1'b1;
      end
    end
  end

  // Outputs decoded from registered state.
  always_comb begin
    pede    = (state_q == ESPERA);
    ocupado = (state_q == ESPERA) || (state_q == PRONTO);
    enable  = (state_q == PRONTO);
  end

  assign sel_sensor        = sel_q;
  assign erro              = erro_q;
  assign contagem_leituras = sets_q;
  assign temperatura       = temp_q;
  assign pH                = ph_q;
  assign luminosidade      = lum_q;
  assign umidade           = umid_q;

endmodule

// File: tb/tb_coletor_sensores.sv
// Testbench for coletor_sensores: directed scenarios plus random traffic,
// every cycle compared against a transaction-level reference model.
module tb_coletor_sensores;

  localparam int TIMEOUT = 15;

  logic       clock = 1'b0;
  logic       reset, inicio, dado_valido;
  logic [3:0] dado_in;
  logic [1:0] sel_sensor;
  logic       pede, enable, ocupado, erro;
  logic [3:0] temperatura, pH, luminosidade, umidade;
  logic [7:0] contagem_leituras;

  coletor_sensores #(.TIMEOUT(TIMEOUT)) dut (
    .clock            (clock),
    .reset            (reset),
    .inicio           (inicio),
    .dado_in          (dado_in),
    .dado_valido      (dado_valido),
    .sel_sensor       (sel_sensor),
    .pede             (pede),
    .temperatura      (temperatura),
    .pH               (pH),
    .luminosidade     (luminosidade),
    .umidade          (umidade),
    .enable           (enable),
    .ocupado          (ocupado),
    .erro             (erro),
    .contagem_leituras(contagem_leituras)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: an acquisition is a list of readings being collected;
  // when four are in hand the set is published for one cycle.
  bit         m_collecting;
  bit         m_publishing;
  bit         m_err;
  int         m_next;       // index of the sensor being asked for
  int         m_silence;    // consecutive cycles without a strobe
  int         m_sets;
  logic [3:0] m_got[4];
  logic [3:0] m_shown[4];

  task automatic model_edge(input logic r, input logic i, input logic v, input logic [3:0] d);
    if (r) begin
      m_collecting = 0; m_publishing = 0; m_err = 0;
      m_next = 0; m_silence = 0; m_sets = 0;
      for (int k = 0; k < 4; k++) begin m_got[k] = 4'd0; m_shown[k] = 4'd0; end
    end else if (m_publishing) begin
      m_publishing = 0;
    end else if (!m_collecting) begin
      if (i) begin
        m_collecting = 1; m_next = 0; m_silence = 0; m_err = 0;
      end
    end else if (v) begin
      m_got[m_next] = d;
      m_silence = 0;
      if (m_next == 3) begin
        m_shown = m_got;
        m_sets = (m_sets + 1) % 256;
        m_collecting = 0;
        m_publishing = 1;
      end else begin
        m_next++;
      end
    end else begin
      m_silence++;
      if (m_silence == TIMEOUT) begin
        m_err = 1;
        m_collecting = 0;
      end
    end
  endtask

  task automatic compare_all();
    check("sel_sensor", sel_sensor, m_next);
    check("pede", pede, m_collecting);
    check("ocupado", ocupado, m_collecting | m_publishing);
    check("enable", enable, m_publishing);
    check("erro", erro, m_err);
    check("contagem", contagem_leituras, m_sets);
    check("temperatura", temperatura, m_shown[0]);
    check("pH", pH, m_shown[1]);
    check("luminosidade", luminosidade, m_shown[2]);
    check("umidade", umidade, m_shown[3]);
  endtask

  task automatic tick(input logic r, input logic i, input logic v, input logic [3:0] d);
    @(negedge clock);
    reset = r; inicio = i; dado_valido = v; dado_in = d;
    @(posedge clock);
    model_edge(r, i, v, d);
    #1;
    compare_all();
  endtask

  task automatic idle();
    tick(1'b0, 1'b0, 1'b0, 4'd0);
  endtask

  task automatic start();
    tick(1'b0, 1'b1, 1'b0, 4'd0);
  endtask

  task automatic strobe(input logic [3:0] d);
    tick(1'b0, 1'b0, 1'b1, d);
  endtask

  logic [3:0] nom[4];

  initial begin
    reset = 1'b1; inicio = 1'b0; dado_valido = 1'b0; dado_in = 4'd0;
    nom[0] = 4'h7; nom[1] = 4'h5; nom[2] = 4'h9; nom[3] = 4'hC;

    // Reset state
    tick(1'b1, 1'b0, 1'b0, 4'd0);
    tick(1'b1, 1'b0, 1'b0, 4'd0);
    check("rst_sel", sel_sensor, 0);
    check("rst_pede", pede, 0);
    check("rst_ocupado", ocupado, 0);
    check("rst_count", contagem_leituras, 0);
    check("rst_temp", temperatura, 0);
    idle();

    // Nominal set: enable four edges after start
    start();
    check("nom_pede", pede, 1);
    check("nom_ocupado", ocupado, 1);
    for (int k = 0; k < 4; k++) begin
      check("nom_sel", sel_sensor, k);
      check("nom_no_enable", enable, 0);
      strobe(nom[k]);
    end
    check("nom_enable", enable, 1);
    check("nom_temp", temperatura, 4'h7);
    check("nom_ph", pH, 4'h5);
    check("nom_lum", luminosidade, 4'h9);
    check("nom_umid", umidade, 4'hC);
    idle();
    check("nom_enable_pulse", enable, 0);
    check("nom_count", contagem_leituras, 1);

    // Slow sensors: three idle cycles before each strobe, enable at start+16
    start();
    for (int k = 0; k < 4; k++) begin
      repeat (3) begin
        idle();
        check("slow_hold_umid", umidade, 4'hC);
        check("slow_no_enable", enable, 0);
      end
      strobe(nom[k]);
      if (k < 3) check("slow_no_enable", enable, 0);
    end
    check("slow_enable", enable, 1);
    check("slow_erro", erro, 0);
    check("slow_temp", temperatura, 4'h7);
    idle();
    check("slow_count", contagem_leituras, 2);

    // Timeout: abort exactly TIMEOUT cycles after the second capture
    start();
    strobe(4'h3);
    strobe(4'h4);
    repeat (TIMEOUT - 1) idle();
    check("to_pede_before", pede, 1);
    check("to_erro_before", erro, 0);
    idle();
    check("to_erro", erro, 1);
    check("to_pede", pede, 0);
    check("to_ocupado", ocupado, 0);
    check("to_enable", enable, 0);
    check("to_temp_kept", temperatura, 4'h7);
    check("to_ph_kept", pH, 4'h5);
    check("to_count_kept", contagem_leituras, 2);
    idle();
    check("to_erro_sticky", erro, 1);
    start();
    check("to_erro_clear", erro, 0);

    // Reset after the third capture
    strobe(4'h1);
    strobe(4'h2);
    strobe(4'h6);
    tick(1'b1, 1'b0, 1'b0, 4'd0);
    check("mid_rst_sel", sel_sensor, 0);
    check("mid_rst_pede", pede, 0);
    check("mid_rst_temp", temperatura, 0);
    check("mid_rst_umid", umidade, 0);
    check("mid_rst_count", contagem_leituras, 0);
    strobe(4'hA);
    strobe(4'hA);
    check("mid_rst_no_start", pede, 0);
    check("mid_rst_no_capture", sel_sensor, 0);

    // Ignored inputs: inicio during ESPERA, dado_valido in OCIOSO
    start();
    strobe(4'h2);
    tick(1'b0, 1'b1, 1'b0, 4'd0);
    check("ign_inicio_sel", sel_sensor, 1);
    strobe(4'h8);
    strobe(4'h1);
    strobe(4'h5);
    check("ign_temp", temperatura, 4'h2);
    check("ign_umid", umidade, 4'h5);
    idle();
    repeat (3) strobe(4'hF);
    check("ign_idle_temp", temperatura, 4'h2);
    check("ign_idle_count", contagem_leituras, 1);
    check("ign_idle_pede", pede, 0);

    // Strobe on exactly the TIMEOUT-th wait cycle is captured
    start();
    repeat (TIMEOUT - 1) idle();
    strobe(4'h9);
    check("bnd_erro", erro, 0);
    check("bnd_sel", sel_sensor, 1);
    check("bnd_pede", pede, 1);
    strobe(4'hA);
    strobe(4'hB);
    strobe(4'hC);
    check("bnd_enable", enable, 1);
    check("bnd_temp", temperatura, 4'h9);
    idle();

    // Random traffic
    for (int c = 0; c < 800; c++) begin
      logic r, i, v;
      r = ($urandom_range(0, 149) == 0);
      i = ($urandom_range(0, 4) == 0);
      v = (c < 400) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      tick(r, i, v, 4'($urandom_range(0, 15)));
    end

    // 256 completed sets wrap the counter to zero
    tick(1'b1, 1'b0, 1'b0, 4'd0);
    for (int s = 0; s < 256; s++) begin
      start();
      repeat (4) strobe(4'($urandom_range(0, 15)));
      idle();
      if (s == 254) check("wrap_255", contagem_leituras, 255);
    end
    check("wrap_count", contagem_leituras, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
